// File: rtl/aes_spi_block_seq.sv
// Sequences one 128-bit AES block over the SPI master as back-to-back byte transfers.
// Define AES_SPI_BYTE_SWAP_EN to send and receive byte 0 as the LSB byte instead of the MSB byte.
module aes_spi_block_seq #(
    parameter int unsigned NUM_BYTES     = 16,
    parameter int unsigned BITS_PER_BYTE = 8
) (
    input  logic                   sclk,
    input  logic                   reset,
    input  logic                   start,
    input  logic                   abort,
    input  logic [NUM_BYTES*8-1:0] tx_block,
    input  logic [7:0]             spi_mdo,
    output logic                   spi_cs,
    output logic [7:0]             spi_mds,
    output logic                   busy,
    output logic                   done,
    output logic [NUM_BYTES*8-1:0] rx_block
);

    localparam int unsigned BlockW = NUM_BYTES * 8;
    localparam int unsigned ByteW  = $clog2(NUM_BYTES);
    localparam int unsigned BitW   = $clog2(BITS_PER_BYTE);
    localparam int unsigned SlotW  = $clog2(BlockW);

    localparam logic [ByteW-1:0] LastByte = ByteW'(NUM_BYTES - 1);
    localparam logic [BitW-1:0]  LastBit  = BitW'(BITS_PER_BYTE - 1);

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StCapture,
        StDone
    } state_e;

    state_e             state_q, state_d;
    logic [ByteW-1:0]   byte_cnt_q, byte_cnt_d;
    logic [BitW-1:0]    bit_cnt_q, bit_cnt_d;
    logic [BlockW-1:0]  tx_q, tx_d;
    logic [BlockW-1:0]  rx_q, rx_d;
    logic [SlotW-1:0]   slot_lsb;

    // Bit offset of the current byte's slot, shared by the send and receive paths.
    always_comb begin
`ifdef AES_SPI_BYTE_SWAP_EN
        slot_lsb = SlotW'({byte_cnt_q, 3'b000});
`else
        slot_lsb = SlotW'(BlockW - 8) - SlotW'({byte_cnt_q, 3'b000});
`endif
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        bit_cnt_d  = bit_cnt_q;
        tx_d       = tx_q;
        rx_d       = rx_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    tx_d       = tx_block;
                    byte_cnt_d = '0;
                    bit_cnt_d  = '0;
                    state_d    = StShift;
                end
            end
            StShift: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    bit_cnt_d = bit_cnt_q + 1'b1;
                    if (bit_cnt_q == LastBit) begin
                        state_d = StCapture;
                    end
                end
            end
            StCapture: begin
                if (abort) begin
                    state_d = StIdle;
                end else begin
                    rx_d[slot_lsb +: 8] = spi_mdo;
                    if (byte_cnt_q == LastByte) begin
                        state_d = StDone;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        bit_cnt_d  = '0;
                        state_d    = StShift;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge sclk) begin
        if (reset) begin
            state_q    <= StIdle;
            byte_cnt_q <= '0;
            bit_cnt_q  <= '0;
            tx_q       <= '0;
            rx_q       <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            tx_q       <= tx_d;
            rx_q       <= rx_d;
        end
    end

    // The current byte stays on MDS through its CAPTURE cycle so each byte is held 9 cycles.
    always_comb begin
        busy     = (state_q == StShift) || (state_q == StCapture);
        spi_cs   = ~busy;
        done     = (state_q == StDone);
        spi_mds  = busy ? tx_q[slot_lsb +: 8] : 8'h00;
        rx_block = rx_q;
    end

endmodule
